rob_wb_arbiter: RTL and testbench
=================================

# rob_wb_arbiter

Collects completion records from `NUM_UNITS` execution units, buffers each in a small per-unit FIFO, and drives up to `WB_WIDTH` ROB writeback lanes per cycle using round-robin arbitration with ROB-bank conflict avoidance. It sits between the execution-unit result stage and the ROB writeback port. Its output side carries the same `bank_addr` / `rob_addr` / `phys_rd` / `en` lane bundle the ROB already consumes, plus an exception flag, generalised to a parametrised lane count.

## Interface
Parameters:
- `NUM_UNITS`, default 4: number of completing execution units.
- `WB_WIDTH`, default 2: writeback lanes to the ROB per cycle; legal range 1..`NUM_UNITS`.
- `FIFO_DEPTH`, default 2: entries per unit FIFO; power of two, at least 2.
- `ROB_ADDR_WIDTH`, `DISPATCH_ADDR_WIDTH`, `PHYS_REGS_ADDR_WIDTH`: taken from `parameters`.

Ports:
- `clk` in 1: clock. All state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `flush` in 1: pipeline flush; discards all buffered completions.
- `in_valid[NUM_UNITS]` in 1: unit offers a completion this cycle.
- `in_ready[NUM_UNITS]` out 1: unit FIFO can accept an entry.
- `in_entry[NUM_UNITS]` in `wb_entry_t`: fields `bank_addr`, `rob_addr`, `phys_rd`, `exc`.
- `wb_en[WB_WIDTH]` out 1: lane carries a writeback this cycle.
- `wb_bank_addr[WB_WIDTH]` out `DISPATCH_ADDR_WIDTH`: ROB bank of the lane.
- `wb_rob_addr[WB_WIDTH]` out `ROB_ADDR_WIDTH`: ROB row of the lane.
- `wb_phys_rd[WB_WIDTH]` out `PHYS_REGS_ADDR_WIDTH`: destination physical register.
- `wb_exc[WB_WIDTH]` out 1: completion raised an exception.

## Operation
- Enqueue: an entry is written into unit u's FIFO when `in_valid[u] && in_ready[u] && !flush`.
- `in_ready[u] = count[u] < FIFO_DEPTH`. It is computed from registered count only. A same-cycle dequeue never raises it, so a full FIFO cannot be enqueued into and dequeued from in the same cycle.
- Arbitration is combinational from registered state only; it never depends on `in_valid` or `in_entry`.
  - Scan units starting at `rr_ptr` and wrapping modulo `NUM_UNITS`.
  - Grant unit u if its FIFO is non-empty, fewer than `WB_WIDTH` grants have been issued, and its head `bank_addr` differs from every bank already granted this cycle.
  - A bank-conflicting head is skipped this cycle and stays at its FIFO head.
- Grants fill lanes in scan order, lane 0 first. Unused lanes have `wb_en=0` and all data fields 0.
- Each granted FIFO dequeues its head at the clock edge.
- `rr_ptr` update: if at least one grant was issued, `rr_ptr` moves to (last granted unit + 1) mod `NUM_UNITS`; otherwise it is unchanged.
- Flush: all FIFO counts and pointers clear at the edge. `wb_*` still presents the current cycle's grants, because the ROB ignores writebacks during a flush. Any enqueue in the same cycle is dropped. `rr_ptr` is unchanged.
- There is no ROB back-pressure: the ROB accepts every lane with `wb_en=1`.

## Timing
- Reset values: all FIFOs empty, `rr_ptr=0`, `in_ready` all 1, `wb_en` all 0, all `wb_*` data 0.
- Latency: an entry accepted at edge t is visible on `wb_*` in cycle t+1 at the earliest.
- Throughput: each unit sustains 1 entry/cycle when it is granted every cycle.
- Ordering: entries from one unit leave in enqueue order. There is no ordering guarantee across units.
- Reset asserted mid-operation: all buffered entries are lost immediately and outputs return to reset values asynchronously.
- `WB_WIDTH == NUM_UNITS` with no bank conflicts: every non-empty FIFO is drained each cycle.

## Structure
- `wb_entry_t` (packed struct) goes in `parameters`. `NUM_WB_UNITS` and `WB_WIDTH` defaults are package constants.
- Sub-module `wb_fifo`: a single-clock FIFO parametrised on depth and `wb_entry_t`. It exposes `push`, `pop`, `flush`, `head`, `count`, and `full`/`empty`. It is instantiated `NUM_UNITS` times.
- The arbiter and output-lane packing stay in `rob_wb_arbiter`.

## Test plan
- Reset check: assert `rst` for 3 cycles, then release. All `wb_en=0`, all `in_ready=1`, and the first grant scan starts at unit 0.
- Single entry: unit 2 offers {bank 1, rob 5, prd 17} at edge 0. Cycle 1 shows lane0 `en=1` {1,5,17}, lane1 `en=0`. Cycle 2 shows nothing.
- Round-robin: units 0..3 each hold 2 entries with distinct banks, `WB_WIDTH=2`.
  - Cycle 1 grants units {0,1}, cycle 2 grants {2,3}, cycle 3 grants {0,1}, cycle 4 grants {2,3}; `rr_ptr` advances accordingly.
  - Each unit's two entries emerge in enqueue order.
- Bank conflict: units 0 and 1 both have heads on bank 0, unit 2 on bank 1, `rr_ptr=0`.
  - Grants are unit 0 on lane0 and unit 2 on lane1.
  - Unit 1 is granted the next cycle.
- Full FIFO: unit 3 receives 2 pushes with no grants possible (force conflicts), `FIFO_DEPTH=2`.
  - `in_ready[3]=0`; a third `in_valid` is not accepted.
  - `in_ready[3]` returns to 1 only the cycle after a dequeue.
- Flush: FIFOs hold 5 entries total and `flush` is pulsed together with an `in_valid` on unit 1.
  - The next cycle has all `wb_en=0` and all `in_ready=1`, and the unit 1 entry is absent.

Source files
------------

// File: rtl/parameters.sv
// Shared widths, default unit/lane counts and the writeback record used on the
// path from execution-unit completion to the ROB writeback port.
package parameters;

    localparam int unsigned ROB_ADDR_WIDTH       = 5;
    localparam int unsigned DISPATCH_ADDR_WIDTH  = 2;
    localparam int unsigned PHYS_REGS_ADDR_WIDTH = 6;

    localparam int unsigned NUM_WB_UNITS     = 4;
    localparam int unsigned DEFAULT_WB_WIDTH = 2;

    typedef struct packed {
        logic [DISPATCH_ADDR_WIDTH-1:0]  bank_addr;
        logic [ROB_ADDR_WIDTH-1:0]       rob_addr;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
        logic                            exc;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Single-clock FIFO buffering completion records for one execution unit.
// Pushes into a full FIFO and pops from an empty one are ignored.
module wb_fifo
    import parameters::*;
#(
    parameter int unsigned DEPTH = 2,
    parameter type entry_t = wb_entry_t,
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          push,
    input  entry_t        push_data,
    input  logic          pop,
    output entry_t        head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    entry_t        mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/rob_wb_arbiter.sv
// Buffers completions per execution unit and packs up to WB_WIDTH of them per
// cycle onto the ROB writeback lanes, round-robin, never two on the same bank.
module rob_wb_arbiter
    import parameters::*;
#(
    parameter int unsigned NUM_UNITS  = NUM_WB_UNITS,
    parameter int unsigned WB_WIDTH   = DEFAULT_WB_WIDTH,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic [NUM_UNITS-1:0]            in_valid,
    output logic [NUM_UNITS-1:0]            in_ready,
    input  wb_entry_t                       in_entry     [NUM_UNITS],
    output logic [WB_WIDTH-1:0]             wb_en,
    output logic [DISPATCH_ADDR_WIDTH-1:0]  wb_bank_addr [WB_WIDTH],
    output logic [ROB_ADDR_WIDTH-1:0]       wb_rob_addr  [WB_WIDTH],
    output logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd   [WB_WIDTH],
    output logic [WB_WIDTH-1:0]             wb_exc
);

    localparam int unsigned UW        = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam int unsigned LW        = (WB_WIDTH > 1) ? $clog2(WB_WIDTH) : 1;
    localparam int unsigned CW        = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned NUM_BANKS = 1 << DISPATCH_ADDR_WIDTH;

    wb_entry_t            head  [NUM_UNITS];
    logic [CW-1:0]        count [NUM_UNITS];
    logic [NUM_UNITS-1:0] full;
    logic [NUM_UNITS-1:0] empty;
    logic [NUM_UNITS-1:0] push;
    logic [NUM_UNITS-1:0] grant;
    logic [UW-1:0]        rr_ptr;
    logic [UW-1:0]        rr_next;
    logic [WB_WIDTH-1:0]  lane_en;
    wb_entry_t            lane  [WB_WIDTH];

    for (genvar u = 0; u < NUM_UNITS; u++) begin : g_unit
        // Ready comes from the registered count only; a same-cycle pop never raises it.
        assign in_ready[u] = (count[u] < CW'(FIFO_DEPTH));
        assign push[u]     = in_valid[u] && in_ready[u] && !full[u] && !flush;

        wb_fifo #(
            .DEPTH   (FIFO_DEPTH),
            .entry_t (wb_entry_t)
        ) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .flush     (flush),
            .push      (push[u]),
            .push_data (in_entry[u]),
            .pop       (grant[u]),
            .head      (head[u]),
            .count     (count[u]),
            .full      (full[u]),
            .empty     (empty[u])
        );
    end

    // Scan from rr_ptr; a head whose bank is already taken waits for a later cycle.
    always_comb begin
        logic [LW:0]           n;
        logic [UW:0]           idx;
        logic [NUM_BANKS-1:0]  bank_used;
        grant     = '0;
        lane_en   = '0;
        bank_used = '0;
        n         = '0;
        idx       = '0;
        rr_next   = rr_ptr;
        for (int l = 0; l < WB_WIDTH; l++) begin
            lane[l] = '0;
        end
        for (int i = 0; i < NUM_UNITS; i++) begin
            idx = {1'b0, rr_ptr} + (UW+1)'(i);
            if (idx >= (UW+1)'(NUM_UNITS)) begin
                idx = idx - (UW+1)'(NUM_UNITS);
            end
            if (!empty[idx[UW-1:0]] && (n < (LW+1)'(WB_WIDTH)) &&
                !bank_used[head[idx[UW-1:0]].bank_addr]) begin
                grant[idx[UW-1:0]]                      = 1'b1;
                bank_used[head[idx[UW-1:0]].bank_addr]  = 1'b1;
                lane_en[n[LW-1:0]]                      = 1'b1;
                lane[n[LW-1:0]]                         = head[idx[UW-1:0]];
                n                                       = n + 1'b1;
                rr_next = (idx == (UW+1)'(NUM_UNITS - 1)) ? '0 : UW'(idx + 1'b1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr <= '0;
        end else if (!flush) begin
            rr_ptr <= rr_next;
        end
    end

    for (genvar l = 0; l < WB_WIDTH; l++) begin : g_lane
        assign wb_en[l]        = lane_en[l];
        assign wb_bank_addr[l] = lane[l].bank_addr;
        assign wb_rob_addr[l]  = lane[l].rob_addr;
        assign wb_phys_rd[l]   = lane[l].phys_rd;
        assign wb_exc[l]       = lane[l].exc;
    end

endmodule

// File: tb/tb_rob_wb_arbiter.sv
// Scoreboard bench: directed completions push hand-computed expected lane records,
// and a negedge monitor pops and compares every writeback the DUT presents.
module tb_rob_wb_arbiter;
    import parameters::*;

    localparam int unsigned NU = 4;
    localparam int unsigned WW = 2;

    typedef logic [1:0] uidx_t;

    typedef struct {
        int unsigned lane;
        wb_entry_t   ent;
    } exp_t;

    logic                            clk = 1'b0;
    logic                            rst = 1'b1;
    logic                            flush = 1'b0;
    logic [NU-1:0]                   in_valid = '0;
    logic [NU-1:0]                   in_ready;
    wb_entry_t                       in_entry     [NU];
    logic [WW-1:0]                   wb_en;
    logic [DISPATCH_ADDR_WIDTH-1:0]  wb_bank_addr [WW];
    logic [ROB_ADDR_WIDTH-1:0]       wb_rob_addr  [WW];
    logic [PHYS_REGS_ADDR_WIDTH-1:0] wb_phys_rd   [WW];
    logic [WW-1:0]                   wb_exc;

    exp_t exp_q[$];
    exp_t mon_e;
    int   vectors = 0;
    int   miscompares = 0;

    rob_wb_arbiter #(
        .NUM_UNITS  (NU),
        .WB_WIDTH   (WW),
        .FIFO_DEPTH (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_entry     (in_entry),
        .wb_en        (wb_en),
        .wb_bank_addr (wb_bank_addr),
        .wb_rob_addr  (wb_rob_addr),
        .wb_phys_rd   (wb_phys_rd),
        .wb_exc       (wb_exc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic wb_entry_t mk(input int b, input int r, input int p, input bit e);
        mk.bank_addr = DISPATCH_ADDR_WIDTH'(b);
        mk.rob_addr  = ROB_ADDR_WIDTH'(r);
        mk.phys_rd   = PHYS_REGS_ADDR_WIDTH'(p);
        mk.exc       = e;
    endfunction

    task automatic drive(input uidx_t u, input wb_entry_t e);
        in_valid[u] = 1'b1;
        in_entry[u] = e;
    endtask

    task automatic expect_wb(input int unsigned l, input wb_entry_t e);
        exp_t x;
        x.lane = l;
        x.ent  = e;
        exp_q.push_back(x);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #2;
        in_valid = '0;
        flush    = 1'b0;
    endtask

    task automatic do_reset();
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
        rst      = 1'b1;
        in_valid = '0;
        flush    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        rst = 1'b0;
        check("reset_wb_en", wb_en, 0);
        check("reset_in_ready", in_ready, 4'hf);
    endtask

    // Monitor: every enabled lane must match the next expected record; idle lanes carry zeros.
    always @(negedge clk) begin
        if (!rst) begin
            for (int l = 0; l < WW; l++) begin
                if (wb_en[l]) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_wb: lane %0d got bank %0d rob %0d prd %0d, required no writeback at %0t",
                                 l, wb_bank_addr[l], wb_rob_addr[l], wb_phys_rd[l], $time);
                    end else begin
                        mon_e = exp_q.pop_front();
                        check("wb_lane", l, mon_e.lane);
                        check("wb_bank", wb_bank_addr[l], mon_e.ent.bank_addr);
                        check("wb_rob", wb_rob_addr[l], mon_e.ent.rob_addr);
                        check("wb_prd", wb_phys_rd[l], mon_e.ent.phys_rd);
                        check("wb_exc", wb_exc[l], mon_e.ent.exc);
                    end
                end else begin
                    check("idle_lane_data",
                          {wb_bank_addr[l], wb_rob_addr[l], wb_phys_rd[l], wb_exc[l]}, 0);
                end
            end
        end
    end

    initial begin
        for (int u = 0; u < NU; u++) begin
            in_entry[u] = '0;
        end
        do_reset();

        // Round-robin: rr starts at 0, two entries per unit, distinct banks per pair.
        drive(2'd0, mk(0, 1, 10, 0));
        drive(2'd1, mk(1, 2, 11, 0));
        drive(2'd2, mk(2, 3, 12, 1));
        drive(2'd3, mk(3, 4, 13, 0));
        expect_wb(0, mk(0, 1, 10, 0));
        expect_wb(1, mk(1, 2, 11, 0));
        tick();
        drive(2'd0, mk(0, 5, 20, 0));
        drive(2'd1, mk(1, 6, 21, 0));
        drive(2'd2, mk(2, 7, 22, 0));
        drive(2'd3, mk(3, 8, 23, 1));
        expect_wb(0, mk(2, 3, 12, 1));
        expect_wb(1, mk(3, 4, 13, 0));
        tick();
        check("rr_in_ready", in_ready, 4'b0011);
        expect_wb(0, mk(0, 5, 20, 0));
        expect_wb(1, mk(1, 6, 21, 0));
        tick();
        expect_wb(0, mk(2, 7, 22, 0));
        expect_wb(1, mk(3, 8, 23, 1));
        tick();
        tick();

        // Single entry from unit 2.
        do_reset();
        drive(2'd2, mk(1, 5, 17, 0));
        expect_wb(0, mk(1, 5, 17, 0));
        tick();
        check("single_wb_en_c1", wb_en, 2'b01);
        tick();
        check("single_wb_en_c2", wb_en, 2'b00);
        tick();

        // Bank conflict: unit 1 shares bank 0 with unit 0 and waits a cycle.
        do_reset();
        drive(2'd0, mk(0, 9, 30, 0));
        drive(2'd1, mk(0, 10, 31, 1));
        drive(2'd2, mk(1, 11, 32, 0));
        expect_wb(0, mk(0, 9, 30, 0));
        expect_wb(1, mk(1, 11, 32, 0));
        expect_wb(0, mk(0, 10, 31, 1));
        tick();
        check("conflict_wb_en_c1", wb_en, 2'b11);
        tick();
        check("conflict_wb_en_c2", wb_en, 2'b01);
        tick();
        check("conflict_wb_en_c3", wb_en, 2'b00);

        // Full FIFO on unit 3: lanes taken, then a bank conflict holds it at depth 2.
        do_reset();
        drive(2'd0, mk(0, 12, 40, 0));
        drive(2'd1, mk(1, 13, 41, 0));
        drive(2'd3, mk(2, 14, 42, 0));
        expect_wb(0, mk(0, 12, 40, 0));
        expect_wb(1, mk(1, 13, 41, 0));
        tick();
        check("full_ready_c1", in_ready, 4'b1111);
        drive(2'd3, mk(2, 15, 43, 1));
        drive(2'd2, mk(2, 16, 44, 0));
        expect_wb(0, mk(2, 16, 44, 0));
        tick();
        check("full_ready_c2", in_ready, 4'b0111);
        drive(2'd3, mk(3, 17, 45, 0));
        expect_wb(0, mk(2, 14, 42, 0));
        tick();
        check("full_ready_c3", in_ready, 4'b0111);
        expect_wb(0, mk(2, 15, 43, 1));
        tick();
        check("full_ready_c4", in_ready, 4'b1111);
        tick();
        tick();

        // Flush with five buffered entries and a same-cycle push on unit 1.
        do_reset();
        drive(2'd0, mk(0, 1, 50, 0));
        drive(2'd1, mk(0, 2, 51, 0));
        drive(2'd2, mk(0, 3, 52, 0));
        drive(2'd3, mk(0, 4, 53, 0));
        expect_wb(0, mk(0, 1, 50, 0));
        tick();
        drive(2'd0, mk(0, 5, 54, 0));
        drive(2'd2, mk(0, 6, 55, 0));
        expect_wb(0, mk(0, 2, 51, 0));
        tick();
        check("flush_pre_ready", in_ready, 4'b1011);
        flush = 1'b1;
        drive(2'd1, mk(2, 7, 56, 1));
        tick();
        check("flush_wb_en", wb_en, 2'b00);
        check("flush_in_ready", in_ready, 4'hf);
        tick();
        tick();

        // Asynchronous reset mid-cycle drops the buffered unit 1 entry at once.
        do_reset();
        drive(2'd0, mk(0, 8, 60, 0));
        drive(2'd1, mk(0, 9, 61, 0));
        expect_wb(0, mk(0, 8, 60, 0));
        tick();
        rst = 1'b1;
        #1;
        check("async_rst_wb_en", wb_en, 2'b00);
        check("async_rst_in_ready", in_ready, 4'hf);
        do_reset();
        tick();
        tick();
        check("final_queue_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
